// File: rtl/dcache_axi_master.sv
// Line-fill / write-back master for the data cache: turns single-line client
// requests into one AXI read (AR/R) or write (AW/W/B) burst at a time.
module dcache_axi_master #(
  parameter int          ADDR_W  = 64,
  parameter int          DATA_W  = 512,
  parameter int          TAG_S   = 64,
  parameter int          ID_W    = 16,
  parameter int unsigned ID_VAL  = 1,
  parameter int          TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // client side
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_write,
  output logic                    resp_err,
  output logic [TAG_S-1:0]        resp_tag,
  output logic [DATA_W-1:0]       resp_data,
  // AXI read address / data
  output logic [ID_W-1:0]         arid_o,
  output logic [ADDR_W-1:0]       araddr_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  input  logic [ID_W-1:0]         rid_i,
  input  logic [TAG_S+DATA_W-1:0] rdata_i,
  input  logic                    rvalid_i,
  output logic                    rready_o,
  // AXI write address / data / response
  output logic [ID_W-1:0]         awid_o,
  output logic [ADDR_W-1:0]       awaddr_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [ID_W-1:0]         wid_o,
  output logic [DATA_W-1:0]       wdata_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  input  logic [ID_W-1:0]         bid_i,
  input  logic                    bvalid_i,
  output logic                    bready_o
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [ID_W-1:0]   ID_C     = ID_W'(ID_VAL);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4,
    S_RESP = 3'd5
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                req_ready_q;
  logic                arvalid_q;
  logic                rready_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;
  logic                resp_valid_q;
  logic                resp_write_q;
  logic                resp_err_q;
  logic [TAG_S-1:0]    resp_tag_q;
  logic [DATA_W-1:0]   resp_data_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                aw_done_d;
  logic                w_done_d;
  logic [CNT_W-1:0]    cnt_d;

  // A channel is finished once its valid has dropped or it handshakes this cycle.
  assign aw_done_d = !awvalid_q || awready_i;
  assign w_done_d  = !wvalid_q  || wready_i;
  assign cnt_d     = cnt_q + CNT_W'(1);

  // Transaction FSM; every client and AXI output is a register of this block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_write_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_tag_q   <= '0;
      resp_data_q  <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            addr_q       <= req_addr;
            wdata_q      <= req_wdata;
            resp_write_q <= req_write;
            resp_err_q   <= 1'b0;
            resp_tag_q   <= '0;
            resp_data_q  <= '0;
            req_ready_q  <= 1'b0;
            if (req_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= S_AW_W;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= S_AR;
            end
          end
        end
        S_AR: begin
          if (arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            cnt_q     <= '0;
            state_q   <= S_R;
          end
        end
        S_R: begin
          if (rvalid_i) begin
            rready_q     <= 1'b0;
            resp_tag_q   <= rdata_i[TAG_S+DATA_W-1:DATA_W];
            resp_data_q  <= rdata_i[DATA_W-1:0];
            resp_err_q   <= (rid_i != ID_C);
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else if (cnt_q == TMO_LAST) begin
            rready_q     <= 1'b0;
            resp_tag_q   <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_AW_W: begin
          if (awvalid_q && awready_i) begin
            awvalid_q <= 1'b0;
          end
          if (wvalid_q && wready_i) begin
            wvalid_q <= 1'b0;
          end
          if (aw_done_d && w_done_d) begin
            bready_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= S_B;
          end
        end
        S_B: begin
          if (bvalid_i) begin
            bready_q     <= 1'b0;
            resp_err_q   <= (bid_i != ID_C);
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else if (cnt_q == TMO_LAST) begin
            bready_q     <= 1'b0;
            resp_tag_q   <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          arvalid_q    <= 1'b0;
          rready_q     <= 1'b0;
          awvalid_q    <= 1'b0;
          wvalid_q     <= 1'b0;
          bready_q     <= 1'b0;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_write = resp_write_q;
  assign resp_err   = resp_err_q;
  assign resp_tag   = resp_tag_q;
  assign resp_data  = resp_data_q;

  assign arid_o    = ID_C;
  assign araddr_o  = addr_q;
  assign arvalid_o = arvalid_q;
  assign rready_o  = rready_q;

  assign awid_o    = ID_C;
  assign awaddr_o  = addr_q;
  assign awvalid_o = awvalid_q;
  assign wid_o     = ID_C;
  assign wdata_o   = wdata_q;
  assign wvalid_o  = wvalid_q;
  assign bready_o  = bready_q;

endmodule
